// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, controller states and the flag register layout.
package alu_pkg;

  typedef enum logic [3:0] {
    OpPopcnt = 4'b0000,
    OpOr     = 4'b0001,
    OpXor    = 4'b0010,
    OpShl    = 4'b0011,
    OpShr    = 4'b0100,
    OpSub    = 4'b0101,
    OpAdd    = 4'b0110,
    OpCmp    = 4'b0111,
    OpMovb   = 4'b1000,
    OpMova   = 4'b1001,
    OpAnd    = 4'b1010,
    OpMul    = 4'b1011
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StMulRun
  } alu_state_e;

  typedef struct packed {
    logic zeroflg;
    logic sign;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier; one partial-product step per cycle.
module alu_mul_iter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_next
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     sum;

  // Low half starts as the multiplier and is consumed LSB-first as the product shifts in.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {sum, prod_q[WIDTH-1:1]};
  end

  assign last = (cnt_q == CntW'(MUL_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
    end else if (step) begin
      prod_q <= prod_next;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/busy/done handshake, held flags and iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SHW        = $clog2(WIDTH),
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sc_i,
  input  logic [SHW-1:0]   sv,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             sc_o,
  output logic             zeroflg,
  output logic             sign,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned Msb = WIDTH - 1;

  alu_state_e       state_q, state_d;
  alu_flags_t       flags_q, flags_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             sc_q, sc_d, done_q, done_d;
  logic             mul_load, mul_last;
  logic [2*WIDTH-1:0] prod_next;
  alu_op_e          op;

  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext;
  logic [WIDTH-1:0] cmp_diff, pop_cnt;

  assign op = alu_op_e'(alu_cmd);

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (state_q == StMulRun),
    .a         (in_a),
    .b         (in_b),
    .last      (mul_last),
    .prod_next (prod_next)
  );

  // Shifts are widened by one bit so the bit shifted out lands at a fixed position.
  always_comb begin
    add_ext  = {1'b0, in_a} + {1'b0, in_b};
    sub_ext  = {1'b0, in_a} - {1'b0, in_b} + {{WIDTH{1'b0}}, sc_i};
    shl_ext  = {1'b0, in_a} << sv;
    shr_ext  = {in_a, 1'b0} >> sv;
    cmp_diff = in_a - in_b;
    pop_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + WIDTH'(in_a[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    sc_d        = sc_q;
    done_d      = 1'b0;
    mul_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && op == OpMul) begin
          mul_load = 1'b1;
          state_d  = StMulRun;
        end else if (start) begin
          done_d = 1'b1;
          if (op != OpCmp) begin
            result_d    = '0;
            result_hi_d = '0;
            sc_d        = 1'b0;
          end
          case (op)
            OpPopcnt: result_d = pop_cnt;
            OpOr:     result_d = in_a | in_b;
            OpXor:    result_d = in_a ^ in_b;
            OpAnd:    result_d = in_a & in_b;
            OpMovb:   result_d = in_b;
            OpMova:   result_d = in_a;
            OpShl:    {sc_d, result_d} = {shl_ext[WIDTH], shl_ext[Msb:0]};
            OpShr:    {sc_d, result_d} = {shr_ext[0], shr_ext[WIDTH:1]};
            OpAdd: begin
              {sc_d, result_d}  = add_ext;
              flags_d.zeroflg  = (add_ext[Msb:0] == '0);
              flags_d.sign     = add_ext[Msb];
              flags_d.carry    = add_ext[WIDTH];
              flags_d.overflow = (in_a[Msb] == in_b[Msb]) && (add_ext[Msb] != in_a[Msb]);
            end
            OpSub: begin
              {sc_d, result_d}  = sub_ext;
              flags_d.zeroflg  = (sub_ext[Msb:0] == '0);
              flags_d.sign     = sub_ext[Msb];
              flags_d.carry    = sub_ext[WIDTH];
              flags_d.overflow = (in_a[Msb] != in_b[Msb]) && (sub_ext[Msb] != in_a[Msb]);
            end
            OpCmp: begin
              flags_d.zeroflg  = (cmp_diff == '0);
              flags_d.sign     = cmp_diff[Msb];
              flags_d.carry    = (in_a < in_b);
              flags_d.overflow = (in_a[Msb] != in_b[Msb]) && (cmp_diff[Msb] != in_a[Msb]);
            end
            default: ;
          endcase
        end
      end
      StMulRun: begin
        if (mul_last) begin
          result_d        = prod_next[Msb:0];
          result_hi_d     = prod_next[2*WIDTH-1:WIDTH];
          sc_d            = 1'b0;
          flags_d.zeroflg = (prod_next == '0);
          flags_d.carry   = (prod_next[2*WIDTH-1:WIDTH] != '0);
          done_d          = 1'b1;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      flags_q     <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      sc_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      sc_q        <= sc_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == StMulRun);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign sc_o      = sc_q;
  assign zeroflg   = flags_q.zeroflg;
  assign sign      = flags_q.sign;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] alu_cmd;
  logic [7:0] in_a, in_b;
  logic       sc_i;
  logic [2:0] sv;
  logic       busy, done, sc_o, zeroflg, sign, carry, overflow;
  logic [7:0] result, result_hi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_cmd   (alu_cmd),
    .in_a      (in_a),
    .in_b      (in_b),
    .sc_i      (sc_i),
    .sv        (sv),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .sc_o      (sc_o),
    .zeroflg   (zeroflg),
    .sign      (sign),
    .carry     (carry),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, s, c, o);
    check_eq({tag, ".zeroflg"}, 16'(zeroflg), 16'(z));
    check_eq({tag, ".sign"}, 16'(sign), 16'(s));
    check_eq({tag, ".carry"}, 16'(carry), 16'(c));
    check_eq({tag, ".overflow"}, 16'(overflow), 16'(o));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"}, 16'(busy), 16'd0);
    check_eq({tag, ".done"}, 16'(done), 16'd0);
    check_eq({tag, ".result"}, 16'(result), 16'd0);
    check_eq({tag, ".result_hi"}, 16'(result_hi), 16'd0);
    check_eq({tag, ".sc_o"}, 16'(sc_o), 16'd0);
    check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive a command for one accept edge; returns 1ns after that edge.
  task automatic issue(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [2:0] s);
    @(negedge clk);
    alu_cmd = cmd; in_a = a; in_b = b; sc_i = ci; sv = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_cmd = '0; in_a = '0; in_b = '0; sc_i = 1'b0; sv = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("por");
    @(negedge clk) reset = 1'b0;

    issue(4'b0110, 8'h7F, 8'h01, 1'b0, 3'd0);
    check_eq("add.done", 16'(done), 16'd1);
    check_eq("add.result", 16'(result), 16'h80);
    check_eq("add.sc_o", 16'(sc_o), 16'd0);
    check_flags("add", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 check_eq("add.done_drop", 16'(done), 16'd0);

    issue(4'b0101, 8'h05, 8'h07, 1'b1, 3'd0);
    check_eq("sub.result", 16'(result), 16'hFF);
    check_eq("sub.sc_o", 16'(sc_o), 16'd1);
    check_flags("sub", 1'b0, 1'b1, 1'b1, 1'b0);

    issue(4'b0111, 8'h80, 8'h01, 1'b0, 3'd0);
    check_eq("cmp.done", 16'(done), 16'd1);
    check_eq("cmp.result", 16'(result), 16'hFF);
    check_eq("cmp.sc_o", 16'(sc_o), 16'd1);
    check_flags("cmp", 1'b0, 1'b0, 1'b0, 1'b1);

    issue(4'b0011, 8'h81, 8'h00, 1'b0, 3'd1);
    check_eq("shl.result", 16'(result), 16'h02);
    check_eq("shl.sc_o", 16'(sc_o), 16'd1);
    check_flags("shl", 1'b0, 1'b0, 1'b0, 1'b1);

    issue(4'b0100, 8'h81, 8'h00, 1'b0, 3'd0);
    check_eq("shr0.result", 16'(result), 16'h81);
    check_eq("shr0.sc_o", 16'(sc_o), 16'd0);

    issue(4'b0100, 8'h81, 8'h00, 1'b0, 3'd1);
    check_eq("shr1.result", 16'(result), 16'h40);
    check_eq("shr1.sc_o", 16'(sc_o), 16'd1);

    issue(4'b0000, 8'hB7, 8'h00, 1'b0, 3'd0);
    check_eq("popcnt.result", 16'(result), 16'd6);
    check_eq("popcnt.sc_o", 16'(sc_o), 16'd0);
    check_flags("popcnt", 1'b0, 1'b0, 1'b0, 1'b1);

    issue(4'b1010, 8'hF0, 8'h3C, 1'b0, 3'd0);
    check_eq("and.result", 16'(result), 16'h30);
    issue(4'b0010, 8'hF0, 8'h3C, 1'b0, 3'd0);
    check_eq("xor.result", 16'(result), 16'hCC);
    issue(4'b0001, 8'hF0, 8'h3C, 1'b0, 3'd0);
    check_eq("or.result", 16'(result), 16'hFC);
    issue(4'b1000, 8'hF0, 8'h3C, 1'b0, 3'd0);
    check_eq("movb.result", 16'(result), 16'h3C);

    issue(4'b1100, 8'hAA, 8'h55, 1'b0, 3'd0);
    check_eq("undef.done", 16'(done), 16'd1);
    check_eq("undef.result", 16'(result), 16'd0);
    check_flags("undef", 1'b0, 1'b0, 1'b0, 1'b1);

    // MUL accepted at edge N; an ADD start while busy must be ignored.
    issue(4'b1011, 8'hFF, 8'hFF, 1'b0, 3'd0);
    check_eq("mul.busy_n", 16'(busy), 16'd1);
    check_eq("mul.done_n", 16'(done), 16'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        alu_cmd = 4'b0110; in_a = 8'h01; in_b = 8'h01; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (i < 8) begin
        check_eq($sformatf("mul.busy_%0d", i), 16'(busy), 16'd1);
        check_eq($sformatf("mul.done_%0d", i), 16'(done), 16'd0);
      end
    end
    check_eq("mul.done", 16'(done), 16'd1);
    check_eq("mul.busy_end", 16'(busy), 16'd0);
    check_eq("mul.result", 16'(result), 16'h01);
    check_eq("mul.result_hi", 16'(result_hi), 16'hFE);
    check_flags("mul", 1'b0, 1'b0, 1'b1, 1'b1);

    issue(4'b0110, 8'h01, 8'h02, 1'b0, 3'd0);
    check_eq("b2b.done", 16'(done), 16'd1);
    check_eq("b2b.result", 16'(result), 16'h03);
    check_eq("b2b.result_hi", 16'(result_hi), 16'h00);
    check_flags("b2b", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset partway through a MUL.
    issue(4'b1011, 8'h0F, 8'h0F, 1'b0, 3'd0);
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check_eq($sformatf("rst.no_done_%0d", i), 16'(done), 16'd0);
    end

    issue(4'b1001, 8'h3C, 8'h00, 1'b0, 3'd0);
    check_eq("mova.done", 16'(done), 16'd1);
    check_eq("mova.busy", 16'(busy), 16'd0);
    check_eq("mova.result", 16'(result), 16'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the datapath ALU, generalised to WIDTH bits.
- Adds a start/busy/done handshake, a held flag register, shift carry-out and an iterative unsigned multiply producing a double-width product.
- Sits between the register file and the writeback mux. The core controller issues one command at a time and waits for done.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
SHW, $clog2(WIDTH), shift-amount width
MUL_CYCLES, WIDTH, iterations of the shift-add multiplier (fixed = WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  command valid; accepted only when busy=0
alu_cmd  input  4  operation code, captured on accept
in_a, in_b  input  WIDTH  operands, captured on accept
sc_i  input  1  carry-in for SUB
sv  input  SHW  shift amount for SHL/SHR
busy  output  1  high while a multi-cycle op runs
done  output  1  one-cycle completion pulse
result  output  WIDTH  registered result (product low half for MUL)
result_hi  output  WIDTH  product high half; 0 after any non-MUL op that writes result
sc_o  output  1  registered carry/shift-out
zeroflg, sign, carry, overflow  output  1 each  registered flag register

Behaviour:
- Reset (async, any time incl. mid-MUL): FSM to IDLE; every output and internal register is 0. The aborted op produces no done pulse.
- FSM states:
  - IDLE: start=1 with a single-cycle cmd updates outputs at that edge; done=1 for the following cycle; FSM stays in IDLE.
  - IDLE: start=1 with MUL goes to MUL_RUN; busy=1 from the next cycle.
  - MUL_RUN: one shift-add iteration per cycle for MUL_CYCLES cycles. On the last iteration edge: write result/result_hi/flags, assert done, go to IDLE, busy=0.
  - Accepted at edge N, MUL completes at edge N+WIDTH.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done (busy=0) is accepted normally, giving back-to-back ops.
- Operands are latched on accept; input changes while busy have no effect.
- Commands (extended results are WIDTH+1 bits):
  - 0000 POPCNT: result = number of 1s in in_a.
  - 0001 OR, 0010 XOR, 1010 AND.
  - 0011 SHL: result = in_a << sv; sc_o = last bit shifted out (in_a[WIDTH-sv]); sc_o=0 when sv=0.
  - 0100 SHR: result = in_a >> sv; sc_o = in_a[sv-1]; sc_o=0 when sv=0.
  - 0101 SUB: {sc_o,result} = in_a - in_b + sc_i, modulo 2^(WIDTH+1).
  - 0110 ADD: {sc_o,result} = in_a + in_b.
  - 0111 CMP: diff = in_a - in_b; result and result_hi unchanged; sc_o unchanged.
  - 1000 MOVB: result = in_b. 1001 MOVA: result = in_a.
  - 1011 MUL: unsigned {result_hi,result} = in_a*in_b.
  - 1100-1111: result=0, flags unchanged, done still pulses.
- Flags update only on ADD, SUB, CMP, MUL; all other cmds hold them.
  - ADD/SUB/CMP: zeroflg = (value==0); sign = msb of value.
  - ADD/SUB: carry = sc_o.
  - CMP: carry = (in_a < in_b) unsigned.
  - ADD overflow: operand msbs equal and result msb differs.
  - SUB/CMP overflow: (a msb != b msb) && (value msb != a msb).
  - MUL: zeroflg = (full product==0); carry = (result_hi != 0); sign and overflow held.
- sc_o written only by SHL, SHR, SUB, ADD (0 for POPCNT/logic/MOV/MUL/undefined).

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[3:0] alu_op_e with the opcodes above.
  - FSM state enum {IDLE, MUL_RUN}.
  - Flag struct {zeroflg, sign, carry, overflow}.
- One sub-module, alu_mul_iter: WIDTH-parameterised shift-add unit with load/step/last. It is instantiated once.
- The combinational single-cycle datapath stays in alu_seq.

Test Plan (WIDTH=8):
- Reset: assert reset mid-simulation -> result, result_hi, flags, sc_o, busy, done all 0 immediately, without waiting for a clk edge.
- ADD 8'h7F+8'h01 -> next cycle done=1, result=8'h80, sign=1, overflow=1, carry=0, zeroflg=0.
- SUB 8'h05-8'h07, sc_i=1 -> result=8'hFF, sc_o=1, carry=1, sign=1. Then CMP 8'h80 vs 8'h01 -> result stays 8'hFF; zeroflg=0, sign=0, carry=0, overflow=1.
- SHL 8'h81 sv=1 -> result=8'h02, sc_o=1. SHR 8'h81 sv=0 -> result=8'h81, sc_o=0. POPCNT 8'hB7 -> result=6, flags unchanged.
- MUL 8'hFF*8'hFF -> busy=1 for 8 cycles; done at edge N+8; result=8'h01, result_hi=8'hFE, carry=1, zeroflg=0. A start of ADD at cycle N+3 is ignored; an ADD issued with done accepted back-to-back.
- Reset at cycle N+4 of MUL -> no done pulse, outputs 0. The following MOVA 8'h3C completes in 1 cycle with result=8'h3C.
